// File: rtl/encode_83_sync_if.sv
// Event-request and indexed-output bundle of the 8-to-3 encoder.
// Handshake: a transfer of out_code happens on a rising clk edge where out_valid && out_ready; while out_valid is high and out_ready low, out_valid and out_code are held stable.
interface encode_83_sync_if;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pend;
  logic [3:0] pend_cnt;
  logic       overrun;
  logic       idle;

  modport master (
    output req, out_ready,
    input  out_valid, out_code, pend, pend_cnt, overrun, idle
  );

  modport slave (
    input  req, out_ready,
    output out_valid, out_code, pend, pend_cnt, overrun, idle
  );
endinterface

// File: rtl/encode_83_sync.sv
// Registered 8-to-3 priority encoder: buffers event pulses in a pending bitmap
// and serves one line index per valid/ready transfer.
module encode_83_sync #(
  parameter bit PRIO_MSB = 1'b1
) (
  input logic              clk,
  input logic              rst,
  encode_83_sync_if.slave  bus
);

  logic [7:0] pend_q, pend_d;
  logic [3:0] pend_cnt_q, pend_cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_code_q, out_code_d;
  logic       overrun_q, overrun_d;

  logic [2:0] sel;
  logic       loadable;
  logic       load;
  logic [7:0] clr;

  // Selection looks only at the registered bitmap; later iterations win.
  always_comb begin
    sel = 3'd0;
    if (PRIO_MSB) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) sel = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) sel = i[2:0];
      end
    end
  end

  always_comb begin
    loadable    = !out_valid_q || bus.out_ready;
    load        = loadable && (pend_q != 8'h00);
    clr         = load ? (8'h01 << sel) : 8'h00;
    out_valid_d = loadable ? (pend_q != 8'h00) : out_valid_q;
    out_code_d  = load ? sel : out_code_q;
    // A request on a line being cleared this cycle is a fresh event, not a loss.
    pend_d      = (pend_q & ~clr) | bus.req;
    overrun_d   = overrun_q || ((bus.req & pend_q & ~clr) != 8'h00);
    pend_cnt_d  = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pend_cnt_d = pend_cnt_d + {3'b000, pend_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 8'h00;
      pend_cnt_q  <= 4'd0;
      out_valid_q <= 1'b0;
      out_code_q  <= 3'd0;
      overrun_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.pend      = pend_q;
  assign bus.pend_cnt  = pend_cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.overrun   = overrun_q;
  assign bus.idle      = (pend_q == 8'h00) && !out_valid_q;

endmodule

// File: tb/tb_encode_83_sync.sv
// Bench for encode_83_sync: directed vector table on the MSB-priority instance,
// a hand sequence on the LSB-priority instance, then random traffic against a model.
module tb_encode_83_sync;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  encode_83_sync_if bus_m ();
  encode_83_sync_if bus_l ();

  encode_83_sync #(.PRIO_MSB(1'b1)) u_dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  encode_83_sync #(.PRIO_MSB(1'b0)) u_dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Index 0 models the MSB-priority instance, index 1 the LSB-priority one.
  logic [7:0] m_pend  [2];
  logic       m_valid [2];
  logic [2:0] m_code  [2];
  logic       m_ovr   [2];

  function automatic int pick(input int k, input int p);
    if (k == 0) return $clog2(p + 1) - 1;   // highest set bit
    else        return $clog2(p & -p);      // lowest set bit
  endfunction

  task automatic model_step(input int k, input logic r, input logic [7:0] rq, input logic rdy);
    logic [7:0] clr;
    int s;
    clr = 8'h00;
    if (r) begin
      m_pend[k] = 8'h00; m_valid[k] = 1'b0; m_code[k] = 3'd0; m_ovr[k] = 1'b0;
    end else begin
      if (!m_valid[k] || rdy) begin
        if (m_pend[k] != 8'h00) begin
          s = pick(k, int'(m_pend[k]));
          m_code[k]  = 3'(s);
          m_valid[k] = 1'b1;
          clr        = 8'h01 << s;
        end else begin
          m_valid[k] = 1'b0;
        end
      end
      if ((rq & m_pend[k] & ~clr) != 8'h00) m_ovr[k] = 1'b1;
      m_pend[k] = (m_pend[k] & ~clr) | rq;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("m_valid", int'(bus_m.out_valid), int'(m_valid[0]));
    chk("m_code",  int'(bus_m.out_code),  int'(m_code[0]));
    chk("m_pend",  int'(bus_m.pend),      int'(m_pend[0]));
    chk("m_cnt",   int'(bus_m.pend_cnt),  $countones(m_pend[0]));
    chk("m_ovr",   int'(bus_m.overrun),   int'(m_ovr[0]));
    chk("m_idle",  int'(bus_m.idle),      int'(m_pend[0] == 8'h00 && !m_valid[0]));
    chk("l_valid", int'(bus_l.out_valid), int'(m_valid[1]));
    chk("l_code",  int'(bus_l.out_code),  int'(m_code[1]));
    chk("l_pend",  int'(bus_l.pend),      int'(m_pend[1]));
    chk("l_cnt",   int'(bus_l.pend_cnt),  $countones(m_pend[1]));
    chk("l_ovr",   int'(bus_l.overrun),   int'(m_ovr[1]));
    chk("l_idle",  int'(bus_l.idle),      int'(m_pend[1] == 8'h00 && !m_valid[1]));
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cycle(input logic r, input logic [7:0] rq, input logic rdy);
    rst = r;
    bus_m.req = rq; bus_m.out_ready = rdy;
    bus_l.req = rq; bus_l.out_ready = rdy;
    @(posedge clk);
    model_step(0, r, rq, rdy);
    model_step(1, r, rq, rdy);
    #1;
    model_compare();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic       e_valid;
    logic [2:0] e_code;
    logic [7:0] e_pend;
    logic [3:0] e_cnt;
    logic       e_ovr;
    logic       e_idle;
  } vec_t;

  localparam int NV = 31;
  vec_t vec [NV];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_m.req = 8'h00; bus_m.out_ready = 1'b0;
    bus_l.req = 8'h00; bus_l.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 8'h00; m_valid[k] = 1'b0; m_code[k] = 3'd0; m_ovr[k] = 1'b0;
    end

    //            rst   req    rdy   valid code pend   cnt  ovr  idle
    vec[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1};
    vec[2]  = '{1'b0, 8'h20, 1'b1, 1'b0, 3'd0, 8'h20, 4'd1, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 8'h00, 4'd0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 4'd0, 1'b0, 1'b1};
    vec[5]  = '{1'b0, 8'h91, 1'b1, 1'b0, 3'd5, 8'h91, 4'd3, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h11, 4'd2, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 8'h01, 4'd1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 4'd0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1};
    // stall: code 2 held while out_ready low, then code 1
    vec[10] = '{1'b0, 8'h06, 1'b0, 1'b0, 3'd0, 8'h06, 4'd2, 1'b0, 1'b0};
    vec[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00, 4'd0, 1'b0, 1'b0};
    vec[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 4'd0, 1'b0, 1'b1};
    // request coinciding with the load of the same line is retained
    vec[18] = '{1'b0, 8'h02, 1'b1, 1'b0, 3'd1, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[19] = '{1'b0, 8'h02, 1'b1, 1'b1, 3'd1, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00, 4'd0, 1'b0, 1'b0};
    vec[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 4'd0, 1'b0, 1'b1};
    // request on a pending, unserved line sets overrun
    vec[22] = '{1'b0, 8'h06, 1'b0, 1'b0, 3'd1, 8'h06, 4'd2, 1'b0, 1'b0};
    vec[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b0, 1'b0};
    vec[24] = '{1'b0, 8'h02, 1'b0, 1'b1, 3'd2, 8'h02, 4'd1, 1'b1, 1'b0};
    vec[25] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 4'd0, 1'b1, 1'b1};
    // reset in the middle of a live transfer with a full bitmap
    vec[27] = '{1'b0, 8'hFF, 1'b1, 1'b0, 3'd1, 8'hFF, 4'd8, 1'b1, 1'b0};
    vec[28] = '{1'b0, 8'hFF, 1'b1, 1'b1, 3'd7, 8'hFF, 4'd8, 1'b1, 1'b0};
    vec[29] = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1};
    vec[30] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1};

    for (int i = 0; i < NV; i++) begin
      cycle(vec[i].rst, vec[i].req, vec[i].rdy);
      chk($sformatf("v%0d_valid", i), int'(bus_m.out_valid), int'(vec[i].e_valid));
      chk($sformatf("v%0d_code", i),  int'(bus_m.out_code),  int'(vec[i].e_code));
      chk($sformatf("v%0d_pend", i),  int'(bus_m.pend),      int'(vec[i].e_pend));
      chk($sformatf("v%0d_cnt", i),   int'(bus_m.pend_cnt),  int'(vec[i].e_cnt));
      chk($sformatf("v%0d_ovr", i),   int'(bus_m.overrun),   int'(vec[i].e_ovr));
      chk($sformatf("v%0d_idle", i),  int'(bus_m.idle),      int'(vec[i].e_idle));
    end

    // idle for 10 cycles after reset
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("idle_run", int'(bus_m.idle && bus_l.idle), 1);
    end

    // LSB priority instance: 8'h91 is served as 0, 4, 7
    cycle(1'b0, 8'h91, 1'b1);
    chk("lsb_cnt0", int'(bus_l.pend_cnt), 3);
    cycle(1'b0, 8'h00, 1'b1);
    chk("lsb_code0", int'(bus_l.out_code), 0);
    chk("lsb_cnt1", int'(bus_l.pend_cnt), 2);
    cycle(1'b0, 8'h00, 1'b1);
    chk("lsb_code1", int'(bus_l.out_code), 4);
    chk("lsb_cnt2", int'(bus_l.pend_cnt), 1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("lsb_code2", int'(bus_l.out_code), 7);
    chk("lsb_cnt3", int'(bus_l.pend_cnt), 0);
    chk("lsb_valid", int'(bus_l.out_valid), 1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("lsb_done", int'(bus_l.idle), 1);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] rq;
      logic       rdy;
      logic       r;
      rq  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) == 0);
      cycle(r, rq, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
